// File: rtl/conv_a2_sched_pkg.sv
// Shared layer constants, FSM state encoding and address-width helpers for the
// 5x5 convolution sequencer.
package conv_a2_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam int unsigned DEF_IFM_SIZE          = 14;
  localparam int unsigned DEF_IFM_DEPTH         = 3;
  localparam int unsigned DEF_KERNAL_SIZE       = 5;
  localparam int unsigned DEF_NUMBER_OF_FILTERS = 2;
  localparam int unsigned DEF_PIPE_LATENCY      = 6;
  localparam int unsigned DEF_READ_LATENCY      = 1;

  // Minimum width 1 so single-entry ranges still get a real bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ifm_aw(input int unsigned size, input int unsigned depth);
    return width_of(size * size * depth);
  endfunction

  function automatic int unsigned wm_aw(input int unsigned nf, input int unsigned depth);
    return width_of(nf * depth);
  endfunction

  function automatic int unsigned ofm_aw(input int unsigned size, input int unsigned k,
                                         input int unsigned nf);
    return width_of((size - k + 1) * (size - k + 1) * nf);
  endfunction

endpackage

// File: rtl/conv_a2_sched_if.sv
// Sequencer-facing bundle: layer control, source handshake, memory addresses,
// datapath enable and tagged result strobes.
interface conv_a2_sched_if
  import conv_a2_sched_pkg::*;
#(
  parameter int unsigned IFM_AW = ifm_aw(DEF_IFM_SIZE, DEF_IFM_DEPTH),
  parameter int unsigned WM_AW  = wm_aw(DEF_NUMBER_OF_FILTERS, DEF_IFM_DEPTH),
  parameter int unsigned OFM_AW = ofm_aw(DEF_IFM_SIZE, DEF_KERNAL_SIZE, DEF_NUMBER_OF_FILTERS)
);
  logic              start;
  logic              src_valid;
  logic              issue;
  logic [IFM_AW-1:0] ifm_addr;
  logic [WM_AW-1:0]  wm_addr;
  logic              conv_enable;
  logic              res_valid;
  logic              acc_first;
  logic              acc_last;
  logic [OFM_AW-1:0] ofm_addr;
  logic              busy;
  logic              done;

  modport master (
    input  start, src_valid,
    output issue, ifm_addr, wm_addr, conv_enable,
           res_valid, acc_first, acc_last, ofm_addr, busy, done
  );

  modport slave (
    output start, src_valid,
    input  issue, ifm_addr, wm_addr, conv_enable,
           res_valid, acc_first, acc_last, ofm_addr, busy, done
  );
endinterface

// File: rtl/conv_a2_sched_tag_pipe.sv
// Free-running valid/tag delay line; bubbles carry an all-zero tag so idle
// outputs read as 0.
module conv_tag_pipe #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned TAG_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_valid
);
  logic [DEPTH-1:0] vld;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld[0]   <= in_valid;
      tag_q[0] <= in_valid ? in_tag : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i]   <= vld[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign any_valid = |vld;
endmodule

// File: rtl/conv_a2_sched.sv
// Layer sequencer: walks filter x output pixel x input channel, issues one
// window per accepted step and tags each issue through to the datapath result.
module conv_a2_sched
  import conv_a2_sched_pkg::*;
#(
  parameter int unsigned IFM_SIZE          = DEF_IFM_SIZE,
  parameter int unsigned IFM_DEPTH         = DEF_IFM_DEPTH,
  parameter int unsigned KERNAL_SIZE       = DEF_KERNAL_SIZE,
  parameter int unsigned NUMBER_OF_FILTERS = DEF_NUMBER_OF_FILTERS,
  parameter int unsigned PIPE_LATENCY      = DEF_PIPE_LATENCY,
  parameter int unsigned READ_LATENCY      = DEF_READ_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  conv_a2_sched_if.master  bus
);
  localparam int unsigned OSZ       = IFM_SIZE - KERNAL_SIZE + 1;
  localparam int unsigned TAG_DEPTH = READ_LATENCY + PIPE_LATENCY;
  localparam int unsigned IFM_AW    = ifm_aw(IFM_SIZE, IFM_DEPTH);
  localparam int unsigned WM_AW     = wm_aw(NUMBER_OF_FILTERS, IFM_DEPTH);
  localparam int unsigned OFM_AW    = ofm_aw(IFM_SIZE, KERNAL_SIZE, NUMBER_OF_FILTERS);
  localparam int unsigned D_W       = width_of(IFM_DEPTH);
  localparam int unsigned P_W       = width_of(OSZ);
  localparam int unsigned F_W       = width_of(NUMBER_OF_FILTERS);
  localparam int unsigned TAG_W     = OFM_AW + 2;

  sched_state_t      state;
  logic [D_W-1:0]    d_cnt;
  logic [P_W-1:0]    col_cnt;
  logic [P_W-1:0]    row_cnt;
  logic [F_W-1:0]    f_cnt;

  logic              issue_w;
  logic              d_last, col_last, row_last, f_last;
  logic [OFM_AW-1:0] ofm_addr_w;
  logic [TAG_W-1:0]  tag_in, tag_out;
  logic              tag_any;

  always_comb begin
    issue_w  = (state == ST_RUN) && bus.src_valid;
    d_last   = (d_cnt   == D_W'(IFM_DEPTH - 1));
    col_last = (col_cnt == P_W'(OSZ - 1));
    row_last = (row_cnt == P_W'(OSZ - 1));
    f_last   = (f_cnt   == F_W'(NUMBER_OF_FILTERS - 1));
    ofm_addr_w = OFM_AW'(OSZ * OSZ * 32'(f_cnt) + OSZ * 32'(row_cnt) + 32'(col_cnt));
    tag_in   = {(d_cnt == '0), d_last, ofm_addr_w};
  end

  assign bus.issue    = issue_w;
  assign bus.ifm_addr = IFM_AW'(IFM_SIZE * IFM_SIZE * 32'(d_cnt)
                                + IFM_SIZE * 32'(row_cnt) + 32'(col_cnt));
  assign bus.wm_addr  = WM_AW'(IFM_DEPTH * 32'(f_cnt) + 32'(d_cnt));
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);

  // Counters roll innermost-first: channel, column, row, filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      d_cnt   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      f_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_RUN;
            d_cnt   <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            f_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (issue_w) begin
            if (!d_last) d_cnt <= d_cnt + 1'b1;
            else begin
              d_cnt <= '0;
              if (!col_last) col_cnt <= col_cnt + 1'b1;
              else begin
                col_cnt <= '0;
                if (!row_last) row_cnt <= row_cnt + 1'b1;
                else begin
                  row_cnt <= '0;
                  if (!f_last) f_cnt <= f_cnt + 1'b1;
                  else begin
                    f_cnt <= '0;
                    state <= ST_DRAIN;
                  end
                end
              end
            end
          end
        end
        ST_DRAIN: if (!tag_any) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_ce_direct
      assign bus.conv_enable = issue_w;
    end else begin : g_ce_pipe
      logic [READ_LATENCY-1:0] ce_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ce_q <= '0;
        else       ce_q <= READ_LATENCY'({ce_q, issue_w});
      end
      assign bus.conv_enable = ce_q[READ_LATENCY-1];
    end
  endgenerate

  // Shifts every cycle: the adder tree free-runs, so stalls become bubbles.
  conv_tag_pipe #(
    .DEPTH (TAG_DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_w),
    .in_tag    (tag_in),
    .out_valid (bus.res_valid),
    .out_tag   (tag_out),
    .any_valid (tag_any)
  );

  assign bus.acc_first = tag_out[TAG_W-1];
  assign bus.acc_last  = tag_out[TAG_W-2];
  assign bus.ofm_addr  = tag_out[OFM_AW-1:0];
endmodule

// File: tb/tb_conv_a2_sched.sv
// Directed bench for conv_a2_sched: reset, smoke, stall, random stall, mid-run
// reset and spurious start pulses, with hand-derived cycle/address expectations.
module tb_conv_a2_sched;
  import conv_a2_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  conv_a2_sched_if bus ();

  conv_a2_sched #(
    .IFM_SIZE          (14),
    .IFM_DEPTH         (3),
    .KERNAL_SIZE       (5),
    .NUMBER_OF_FILTERS (2),
    .PIPE_LATENCY      (6),
    .READ_LATENCY      (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int c0    = 0;
  bit logging = 1'b0;

  int iss_ifm[$], iss_wm[$], iss_cyc[$];
  int res_ofm[$], res_cyc[$];
  bit res_first[$], res_last[$];
  int ce_first = -1;
  int done_n   = 0;
  int done_cyc = -1;

  always @(negedge clk) begin
    if (!reset && logging) begin
      if (bus.issue) begin
        iss_ifm.push_back(int'(bus.ifm_addr));
        iss_wm.push_back(int'(bus.wm_addr));
        iss_cyc.push_back(cyc - c0);
      end
      if (bus.conv_enable && ce_first < 0) ce_first = cyc - c0;
      if (bus.res_valid) begin
        res_ofm.push_back(int'(bus.ofm_addr));
        res_first.push_back(bus.acc_first);
        res_last.push_back(bus.acc_last);
        res_cyc.push_back(cyc - c0);
      end
      if (bus.done) begin
        done_n++;
        done_cyc = cyc - c0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_ifm.delete(); iss_wm.delete(); iss_cyc.delete();
    res_ofm.delete(); res_cyc.delete(); res_first.delete(); res_last.delete();
    ce_first = -1;
    done_n   = 0;
    done_cyc = -1;
  endtask

  // Leaves the bench at relative cycle 1 with start already dropped.
  task automatic begin_run(input bit sv);
    clear_logs();
    tick();
    c0 = cyc;
    bus.start = 1'b1;
    bus.src_valid = sv;
    logging = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_n > 0), 1);
    repeat (4) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_issue"},       32'(bus.issue), 0);
    chk({tag, "_conv_enable"}, 32'(bus.conv_enable), 0);
    chk({tag, "_res_valid"},   32'(bus.res_valid), 0);
    chk({tag, "_acc_first"},   32'(bus.acc_first), 0);
    chk({tag, "_acc_last"},    32'(bus.acc_last), 0);
    chk({tag, "_busy"},        32'(bus.busy), 0);
    chk({tag, "_done"},        32'(bus.done), 0);
    chk({tag, "_ifm_addr"},    32'(bus.ifm_addr), 0);
    chk({tag, "_wm_addr"},     32'(bus.wm_addr), 0);
    chk({tag, "_ofm_addr"},    32'(bus.ofm_addr), 0);
  endtask

  // Reference walk: k-th issue/result is channel k%3 of pixel k/3.
  task automatic check_model(input string tag);
    int err = 0;
    int n;
    chk({tag, "_res_count"}, 32'(res_ofm.size()), 600);
    chk({tag, "_iss_count"}, 32'(iss_cyc.size()), 600);
    n = (res_ofm.size() < iss_cyc.size()) ? res_ofm.size() : iss_cyc.size();
    for (int k = 0; k < n; k++) begin
      int d, pix, f, r, c;
      d   = k % 3;
      pix = k / 3;
      f   = pix / 100;
      r   = (pix % 100) / 10;
      c   = pix % 10;
      if (res_ofm[k] != pix) err++;
      if (res_first[k] != (d == 0)) err++;
      if (res_last[k] != (d == 2)) err++;
      if (iss_ifm[k] != d * 196 + r * 14 + c) err++;
      if (iss_wm[k] != f * 3 + d) err++;
      if (res_cyc[k] - iss_cyc[k] != 7) err++;
    end
    chk({tag, "_seq_errors"}, 32'(err), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Smoke: src_valid held high for the whole layer.
    begin_run(1'b1);
    wait_done(700, "smoke");
    chk("smoke_first_issue_cyc", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 1);
    chk("smoke_first_ce_cyc", 32'(ce_first), 2);
    chk("smoke_done_count", 32'(done_n), 1);
    chk("smoke_done_cyc", 32'(done_cyc), 609);
    if (res_ofm.size() == 600 && iss_cyc.size() == 600) begin
      chk("smoke_iss0_ifm", 32'(iss_ifm[0]), 0);
      chk("smoke_iss0_wm", 32'(iss_wm[0]), 0);
      chk("smoke_res0_cyc", 32'(res_cyc[0]), 8);
      chk("smoke_res0_first", 32'(res_first[0]), 1);
      chk("smoke_res0_last", 32'(res_last[0]), 0);
      chk("smoke_res0_ofm", 32'(res_ofm[0]), 0);
      chk("smoke_res2_last", 32'(res_last[2]), 1);
      chk("wrap_res3_ofm", 32'(res_ofm[3]), 1);
      chk("wrap_iss3_ifm", 32'(iss_ifm[3]), 1);
      chk("wrap_iss3_wm", 32'(iss_wm[3]), 0);
      chk("wrap_res30_ofm", 32'(res_ofm[30]), 10);
      chk("wrap_iss30_ifm", 32'(iss_ifm[30]), 14);
      chk("wrap_res300_ofm", 32'(res_ofm[300]), 100);
      chk("wrap_iss300_wm", 32'(iss_wm[300]), 3);
      chk("wrap_res599_ofm", 32'(res_ofm[599]), 199);
      chk("wrap_iss599_wm", 32'(iss_wm[599]), 5);
      chk("wrap_res599_last", 32'(res_last[599]), 1);
    end
    check_model("smoke");
    chk("smoke_idle_busy", 32'(bus.busy), 0);

    // Stall: src_valid low for relative cycles 3..5.
    begin_run(1'b1);
    tick();                       // rel 2
    tick();                       // rel 3
    bus.src_valid = 1'b0;
    #1;
    chk("stall_c3_issue", 32'(bus.issue), 0);
    chk("stall_c3_ifm", 32'(bus.ifm_addr), 392);
    chk("stall_c3_wm", 32'(bus.wm_addr), 2);
    chk("stall_c3_ce", 32'(bus.conv_enable), 1);
    tick();                       // rel 4
    #1;
    chk("stall_c4_issue", 32'(bus.issue), 0);
    chk("stall_c4_ifm", 32'(bus.ifm_addr), 392);
    chk("stall_c4_ce", 32'(bus.conv_enable), 0);
    tick();                       // rel 5
    #1;
    chk("stall_c5_ifm", 32'(bus.ifm_addr), 392);
    chk("stall_c5_ce", 32'(bus.conv_enable), 0);
    tick();                       // rel 6
    bus.src_valid = 1'b1;
    #1;
    chk("stall_c6_issue", 32'(bus.issue), 1);
    chk("stall_c6_ifm", 32'(bus.ifm_addr), 392);
    chk("stall_c6_ce", 32'(bus.conv_enable), 0);
    wait_done(700, "stall");
    if (res_cyc.size() >= 4) begin
      chk("stall_res1_cyc", 32'(res_cyc[1]), 9);
      chk("stall_res2_cyc", 32'(res_cyc[2]), 13);
      chk("stall_res2_ofm", 32'(res_ofm[2]), 0);
      chk("stall_res2_last", 32'(res_last[2]), 1);
    end
    chk("stall_done_cyc", 32'(done_cyc), 612);
    check_model("stall");

    // Random src_valid at roughly 50% duty.
    clear_logs();
    tick();
    c0 = cyc;
    bus.start = 1'b1;
    bus.src_valid = 1'(($urandom_range(0, 1)));
    logging = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 5000 && done_n == 0; n++) begin
      bus.src_valid = 1'($urandom_range(0, 1));
      tick();
    end
    bus.src_valid = 1'b1;
    chk("rand_done_seen", 32'(done_n), 1);
    repeat (4) tick();
    check_model("rand");
    if (res_cyc.size() == 600)
      chk("rand_done_after_last", 32'(done_cyc), 32'(res_cyc[599] + 2));

    // Reset asserted mid-run after 100 issues.
    begin_run(1'b1);
    for (int n = 0; n < 300 && iss_cyc.size() < 100; n++) tick();
    chk("midrst_issued_100", 32'(iss_cyc.size() >= 100), 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    tick();
    tick();
    clear_logs();
    reset = 1'b0;
    repeat (20) tick();
    chk("midrst_no_res_after", 32'(res_ofm.size()), 0);
    chk("midrst_no_issue_after", 32'(iss_cyc.size()), 0);
    chk("midrst_no_done_after", 32'(done_n), 0);
    chk("midrst_idle_busy", 32'(bus.busy), 0);
    begin_run(1'b1);
    wait_done(700, "rerun");
    if (res_ofm.size() > 0) chk("rerun_res0_ofm", 32'(res_ofm[0]), 0);
    check_model("rerun");

    // Start pulsed in RUN, DRAIN and the DONE cycle.
    begin_run(1'b1);
    for (int r = 1; r < 630; r++) begin
      bus.start = (r == 50 || r == 603 || r == 609);
      tick();
    end
    bus.start = 1'b0;
    chk("spur_done_count", 32'(done_n), 1);
    chk("spur_done_cyc", 32'(done_cyc), 609);
    chk("spur_busy_after", 32'(bus.busy), 0);
    check_model("spur");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
